// File: rtl/capiano_pkg.sv
// Shared constants, pixel field layout, FSM encoding and the luma helper
// for the camera-piano key detector.
package capiano_pkg;

    localparam int NUM_KEYS   = 8;
    localparam int KEY_WIDTH  = 80;
    localparam int ROI_Y0     = 200;
    localparam int ROI_Y1     = 280;
    localparam int DARK_LEVEL = 6;
    localparam int THRESH     = 800;
    localparam int DEBOUNCE   = 3;

    localparam int CNT_W  = $clog2(KEY_WIDTH * (ROI_Y1 - ROI_Y0) + 1);
    localparam int Y_W    = 10;
    localparam int ZONE_W = $clog2(NUM_KEYS + 1);
    localparam int ZX_W   = $clog2(KEY_WIDTH);
    localparam int IDX_W  = $clog2(NUM_KEYS);
    localparam int RUN_W  = $clog2(DEBOUNCE + 1);

    localparam int PIX_R_LSB = 6;
    localparam int PIX_G_LSB = 3;
    localparam int PIX_B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_EVAL   = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

    function automatic logic [4:0] luma_sum(input logic [8:0] pix);
        luma_sum = 5'(pix[PIX_R_LSB +: 3]) + 5'(pix[PIX_G_LSB +: 3]) + 5'(pix[PIX_B_LSB +: 3]);
    endfunction

endpackage

// File: rtl/key_detector_debounce.sv
// Per-key debounce: lets a key flip only after DEBOUNCE consecutive frames
// whose raw decision disagrees with the current key state.
module key_debounce
    import capiano_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic upd_i,
    input  logic cur_i,
    input  logic raw_i,
    output logic next_o
);

    logic [RUN_W-1:0] run_q, run_d;
    logic             flip_s;

    // run counter next state and flip decision, evaluated once per frame update
    always_comb begin
        run_d  = run_q;
        flip_s = 1'b0;
        if (upd_i) begin
            if (raw_i != cur_i) begin
                if (run_q == RUN_W'(DEBOUNCE - 1)) begin
                    flip_s = 1'b1;
                    run_d  = '0;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end else begin
                run_d = '0;
            end
        end else begin
            run_d = run_q;
        end
        next_o = flip_s ? raw_i : cur_i;
    end

    // run counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/key_detector.sv
// Counts dark pixels per key zone inside a row band and decides once per frame
// which keys are pressed. Define KEY_DEBOUNCE_EN to debounce each key over frames.
module key_detector
    import capiano_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pix_valid_i,
    input  logic                pix_sof_i,
    input  logic                pix_eol_i,
    input  logic [8:0]          pix_data_i,
    output logic [NUM_KEYS-1:0] key_state_o,
    output logic [NUM_KEYS-1:0] key_press_o,
    output logic                frame_done_o,
    output logic [31:0]         debug_out_o
);

    state_e              state_q, state_d;
    logic [Y_W-1:0]      y_q, y_d, y_s;
    logic [ZONE_W-1:0]   zone_q, zone_d, zone_s;
    logic [ZX_W-1:0]     zx_q, zx_d, zx_s;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_KEYS-1:0] raw_q, raw_d;
    logic [NUM_KEYS-1:0] key_state_q, key_state_d;
    logic [NUM_KEYS-1:0] key_press_q, key_press_d;
    logic [NUM_KEYS-1:0] new_state_s;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                accept_s, dark_s, in_roi_s, upd_s;

    // position of the current pixel; a sof pixel always sits at the origin
    always_comb begin
        if (pix_sof_i) begin
            y_s    = '0;
            zone_s = '0;
            zx_s   = '0;
        end else begin
            y_s    = y_q;
            zone_s = zone_q;
            zx_s   = zx_q;
        end
        in_roi_s = (y_s >= Y_W'(ROI_Y0)) && (y_s < Y_W'(ROI_Y1)) && (zone_s < ZONE_W'(NUM_KEYS));
        dark_s   = luma_sum(pix_data_i) < 5'(DARK_LEVEL);
        accept_s = pix_valid_i && (((state_q == ST_IDLE) && pix_sof_i) || (state_q == ST_ACCUM));
        upd_s    = (state_q == ST_UPDATE);
    end

    // next state, pixel position tracking, zone accumulation and frame decision
    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        zone_d       = zone_q;
        zx_d         = zx_q;
        idx_d        = idx_q;
        raw_d        = raw_q;
        key_state_d  = key_state_q;
        key_press_d  = '0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k] = cnt_q[k];
        end

        if (accept_s) begin
            // zone index is tracked incrementally so no divider is needed for x/KEY_WIDTH
            if (pix_eol_i) begin
                zx_d   = '0;
                zone_d = '0;
                y_d    = (y_s == {Y_W{1'b1}}) ? y_s : y_s + Y_W'(1);
            end else if (zx_s == ZX_W'(KEY_WIDTH - 1)) begin
                zx_d   = '0;
                zone_d = (zone_s == ZONE_W'(NUM_KEYS)) ? zone_s : zone_s + ZONE_W'(1);
            end else begin
                zx_d   = zx_s + ZX_W'(1);
                zone_d = zone_s;
            end
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (pix_sof_i) begin
                    cnt_d[k] = '0;
                end else begin
                    cnt_d[k] = cnt_q[k];
                end
                if (dark_s && in_roi_s && (zone_s == ZONE_W'(k)) && (cnt_d[k] != {CNT_W{1'b1}})) begin
                    cnt_d[k] = cnt_d[k] + CNT_W'(1);
                end else begin
                    cnt_d[k] = cnt_d[k];
                end
            end
        end else begin
            zx_d = zx_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pix_valid_i && pix_sof_i) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (pix_valid_i && pix_eol_i && (y_s == Y_W'(ROI_Y1 - 1))) begin
                    state_d = ST_EVAL;
                    idx_d   = '0;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_EVAL: begin
                raw_d[idx_q] = (cnt_q[idx_q] >= CNT_W'(THRESH));
                if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
                    state_d = ST_UPDATE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_UPDATE: begin
                key_state_d  = new_state_s;
                key_press_d  = new_state_s & ~key_state_q;
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 8'd1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // any sof outside IDLE abandons a frame
        if (pix_valid_i && pix_sof_i && (state_q != ST_IDLE)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_d;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_db
        key_debounce u_db (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .upd_i  (upd_s),
            .cur_i  (key_state_q[k]),
            .raw_i  (raw_q[k]),
            .next_o (new_state_s[k])
        );
    end
`else
    assign new_state_s = raw_q;
`endif

    // state and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            y_q          <= '0;
            zone_q       <= '0;
            zx_q         <= '0;
            idx_q        <= '0;
            raw_q        <= '0;
            key_state_q  <= '0;
            key_press_q  <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            drop_cnt_q   <= 8'd0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            zone_q       <= zone_d;
            zx_q         <= zx_d;
            idx_q        <= idx_d;
            raw_q        <= raw_d;
            key_state_q  <= key_state_d;
            key_press_q  <= key_press_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign key_state_o  = key_state_q;
    assign key_press_o  = key_press_q;
    assign frame_done_o = frame_done_q;
    assign debug_out_o  = {drop_cnt_q, frame_cnt_q, 8'h00, 8'(key_state_q)};

endmodule

// File: tb/tb_key_detector.sv
// Directed bench for key_detector: drives synthetic frames and checks the
// key bitmap, press pulses, frame_done latency and debug counters.
module tb_key_detector;

    localparam int KW = 80;
`ifdef KEY_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, sof, eol;
    logic [8:0]  data;
    logic [7:0]  key_state, key_press;
    logic        frame_done;
    logic [31:0] debug_out;

    int n_chk = 0;
    int n_bad = 0;
    int fd_pulses = 0;
    int fd_before;

    key_detector dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pix_valid_i  (valid),
        .pix_sof_i    (sof),
        .pix_eol_i    (eol),
        .pix_data_i   (data),
        .key_state_o  (key_state),
        .key_press_o  (key_press),
        .frame_done_o (frame_done),
        .debug_out_o  (debug_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) fd_pulses <= fd_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic put_pix(input logic s, input logic e, input logic [8:0] d);
        valid = 1'b1; sof = s; eol = e; data = d;
        @(posedge clk); #1;
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
    endtask

    task automatic send_line(input int len, input int lo, input int hi, input bit first);
        logic [8:0] px;
        for (int i = 0; i < len; i++) begin
            px = (i >= lo && i < hi) ? 9'h000 : 9'h1FF;
            put_pix(first && (i == 0), i == len - 1, px);
        end
    endtask

    // 200 rows above the band, then 80 band rows; dark pixels only in one zone
    task automatic send_frame(input int zone, input int full, input int extra,
                              input bit pre_dark, input bit eval_sof, output int lat);
        int lo;
        lo = zone * KW;
        for (int y = 0; y < 200; y++) begin
            if (y == 199 && pre_dark) send_line(lo + KW, lo, lo + KW, 1'b0);
            else                      send_line(1, 0, 0, y == 0);
        end
        for (int r = 0; r < 80; r++) begin
            if (r < full)                     send_line(lo + KW, lo, lo + KW, 1'b0);
            else if (r == full && extra > 0)  send_line(lo + extra, lo, lo + extra, 1'b0);
            else                              send_line(1, 0, 0, 1'b0);
        end
        lat = 1;
        while (frame_done !== 1'b1 && lat < 40) begin
            if (eval_sof && lat == 3) begin
                valid = 1'b1; sof = 1'b1; data = 9'h1FF;
            end
            @(posedge clk); #1;
            valid = 1'b0; sof = 1'b0;
            lat++;
        end
    endtask

    task automatic do_frame(input string nm, input int zone, input int full, input int extra,
                            input bit pre_dark, input bit eval_sof,
                            input logic [7:0] exp_st, input logic [7:0] exp_pr);
        int lat;
        send_frame(zone, full, extra, pre_dark, eval_sof, lat);
        check_eq({nm, "_lat"}, lat, 10);
        check_eq({nm, "_state"}, key_state, exp_st);
        check_eq({nm, "_press"}, key_press, exp_pr);
        @(posedge clk); #1;
        check_eq({nm, "_pulse_end"}, {23'd0, frame_done, key_press}, 32'd0);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; valid = 1'b0; sof = 1'b0; eol = 1'b0; data = 9'h000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", key_state, 8'h00);
        check_eq("rst_press", key_press, 8'h00);
        check_eq("rst_done", frame_done, 1'b0);
        check_eq("rst_debug", debug_out, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_frame("white1", 0, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        check_eq("fcnt1", debug_out[23:16], 8'd1);
        do_frame("z2full", 2, 80, 0, 1'b0, 1'b0, DB_EN ? 8'h00 : 8'h04, DB_EN ? 8'h00 : 8'h04);
        do_frame("z2b", 2, 10, 0, 1'b0, 1'b0, DB_EN ? 8'h00 : 8'h04, 8'h00);
        do_frame("z2c", 2, 10, 0, 1'b0, 1'b0, 8'h04, DB_EN ? 8'h04 : 8'h00);
        do_frame("white2", 0, 0, 0, 1'b0, 1'b0, DB_EN ? 8'h04 : 8'h00, 8'h00);
        do_frame("z5_799", 5, 9, 79, 1'b1, 1'b0, DB_EN ? 8'h04 : 8'h00, 8'h00);
        do_frame("z5_800", 5, 10, 0, 1'b1, 1'b0, DB_EN ? 8'h00 : 8'h20, DB_EN ? 8'h00 : 8'h20);

        // restart mid-frame, then a sof while the completed frame is evaluated
        fd_before = fd_pulses;
        send_line(1, 0, 0, 1'b1);
        for (int i = 0; i < 50; i++) send_line(1, 0, 0, 1'b0);
        do_frame("drop", 0, 0, 0, 1'b0, 1'b1, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        check_eq("drop_cnt", debug_out[31:24], 8'd2);
        check_eq("drop_fd_once", fd_pulses - fd_before, 1);
        check_eq("fcnt8", debug_out[23:16], 8'd8);

        for (int i = 0; i < (DB_EN ? 3 : 1); i++) send_frame(2, 10, 0, 1'b0, 1'b0, lat);
        @(posedge clk); #1;
        check_eq("pre_rst_state", key_state, 8'h04);

        send_line(1, 0, 0, 1'b1);
        for (int i = 0; i < 210; i++) send_line(1, 0, 0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_state", key_state, 8'h00);
        check_eq("arst_press", key_press, 8'h00);
        check_eq("arst_done", frame_done, 1'b0);
        check_eq("arst_debug", debug_out, 32'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_frame("post_rst", 2, 10, 0, 1'b0, 1'b0, DB_EN ? 8'h00 : 8'h04, DB_EN ? 8'h00 : 8'h04);
        check_eq("post_rst_debug", debug_out, {8'd0, 8'd1, 8'd0, (DB_EN ? 8'h00 : 8'h04)});

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
